// File: rtl/sha3_digest_collect.sv
// Collects the 8-beat Keccak permutation output, keeps the digest portion,
// buffers up to two finished digests and streams them out as 64-bit words.
module sha3_digest_collect #(
  parameter int DIGEST_BITS = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_push,
  input  logic [2:0]   in_ix,
  input  logic [199:0] in_dat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_word,
  output logic         out_last,
  output logic         err_seq,
  output logic         err_ovf,
  output logic [7:0]   err_cnt
);

  localparam int NW  = DIGEST_BITS / 64;
  localparam int WPW = $clog2(NW);
  localparam logic [WPW-1:0] WP_LAST = WPW'(NW - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state, state_n;
  logic [2:0]       exp_q, exp_n;
  logic             cap, done, seq_bad;

  logic [DIGEST_BITS-1:0] dig_buf;
  logic [DIGEST_BITS-1:0] slot [2];
  logic             head, head_n, wr;
  logic [1:0]       cnt, cnt_n;
  logic [WPW-1:0]   wp, wp_n;
  logic             xfer, pop, commit_ok, ovf;
  logic [DIGEST_BITS-1:0] hd_data;
  logic [63:0]      word_n;
  logic             last_n;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Beat-index sequencing: decide capture, frame completion and sequence errors
  always_comb begin
    state_n = state;
    exp_n   = exp_q;
    cap     = 1'b0;
    done    = 1'b0;
    seq_bad = 1'b0;
    if (in_push) begin
      case (state)
        IDLE: begin
          if (in_ix == 3'd0) begin
            state_n = COLLECT;
            exp_n   = 3'd1;
            cap     = 1'b1;
          end else begin
            seq_bad = 1'b1;
          end
        end
        COLLECT: begin
          if (in_ix == exp_q) begin
            cap = 1'b1;
            if (exp_q == 3'd7) begin
              done    = 1'b1;
              state_n = IDLE;
              exp_n   = 3'd0;
            end else begin
              exp_n = exp_q + 3'd1;
            end
          end else begin
            seq_bad = 1'b1;
            if (in_ix == 3'd0) begin
              exp_n = 3'd1;
              cap   = 1'b1;
            end else begin
              state_n = IDLE;
              exp_n   = 3'd0;
            end
          end
        end
        default: begin
          state_n = IDLE;
          exp_n   = 3'd0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      exp_q <= 3'd0;
    end else begin
      state <= state_n;
      exp_q <= exp_n;
    end
  end

  // Keep only the state bits that belong to the digest; later beats just advance exp
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int b = 0; b < DIGEST_BITS; b++) begin
        if (in_ix == 3'(b / 200)) dig_buf[b] <= in_dat[b % 200];
      end
    end
  end

  // FIFO/serializer next state; a pop in the same cycle frees a slot for the commit
  always_comb begin
    xfer      = out_valid & out_ready;
    pop       = xfer & out_last;
    commit_ok = done & ((cnt != 2'd2) | pop);
    ovf       = done & ~commit_ok;
    wr        = head ^ cnt[0];
    head_n    = head ^ pop;
    cnt_n     = cnt - {1'b0, pop} + {1'b0, commit_ok};
    wp_n      = wp;
    if (xfer) wp_n = (wp == WP_LAST) ? '0 : wp + 1'b1;
    hd_data   = (commit_ok && (wr == head_n)) ? dig_buf : slot[head_n];
    word_n    = hd_data[{wp_n, 6'b0} +: 64];
    last_n    = (cnt_n != 2'd0) && (wp_n == WP_LAST);
  end

  // Digest storage
  always_ff @(posedge clk) begin
    if (commit_ok) slot[wr] <= dig_buf;
  end

  // FIFO control and registered output word
  always_ff @(posedge clk) begin
    if (!reset) begin
      head      <= 1'b0;
      cnt       <= 2'd0;
      wp        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_word  <= 64'd0;
    end else begin
      head      <= head_n;
      cnt       <= cnt_n;
      wp        <= wp_n;
      out_valid <= (cnt_n != 2'd0);
      out_last  <= last_n;
      out_word  <= (cnt_n != 2'd0) ? word_n : 64'd0;
    end
  end

  // Error pulses and saturating error counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_seq <= 1'b0;
      err_ovf <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err_seq <= seq_bad;
      err_ovf <= ovf;
      err_cnt <= sat_add(err_cnt, {1'b0, seq_bad} + {1'b0, ovf});
    end
  end

endmodule

// File: tb/tb_sha3_digest_collect.sv
// Bench for sha3_digest_collect: 256- and 512-bit instances share stimulus and
// are compared every cycle against a queue-of-digests reference model.
module tb_sha3_digest_collect;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         push;
  logic [2:0]   ix;
  logic [199:0] dat;
  logic         rdy;

  logic         v0, l0, es0, eo0;
  logic [63:0]  w0;
  logic [7:0]   ec0;
  logic         v1, l1, es1, eo1;
  logic [63:0]  w1;
  logic [7:0]   ec1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sha3_digest_collect #(.DIGEST_BITS(256)) u256 (
    .clk(clk), .reset(rst_n), .in_push(push), .in_ix(ix), .in_dat(dat),
    .out_valid(v0), .out_ready(rdy), .out_word(w0), .out_last(l0),
    .err_seq(es0), .err_ovf(eo0), .err_cnt(ec0));

  sha3_digest_collect #(.DIGEST_BITS(512)) u512 (
    .clk(clk), .reset(rst_n), .in_push(push), .in_ix(ix), .in_dat(dat),
    .out_valid(v1), .out_ready(rdy), .out_word(w1), .out_last(l1),
    .err_seq(es1), .err_ovf(eo1), .err_cnt(ec1));

  // Reference model: whole 1600-bit state, expected index, 2-deep digest queue
  logic [1599:0] s_cur;
  int            m_exp;
  logic [1599:0] mq [2][2];
  int            mcnt [2];
  int            mwp [2];
  int            mec [2];
  bit            m_es;
  bit            m_eo [2];
  bit            was_rst;
  int            nw [2] = '{4, 8};

  function automatic logic [199:0] rnd200();
    logic [223:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom()};
    return t[199:0];
  endfunction

  task automatic model_edge();
    bit done;
    int ixi;
    ixi = int'(ix);
    done = 1'b0;
    if (!rst_n) begin
      m_exp = 0;
      m_es = 1'b0;
      was_rst = 1'b1;
      for (int m = 0; m < 2; m++) begin
        mcnt[m] = 0; mwp[m] = 0; mec[m] = 0; m_eo[m] = 1'b0;
      end
      return;
    end
    was_rst = 1'b0;
    m_es = 1'b0;
    if (push) begin
      if (ixi == m_exp) begin
        s_cur[ixi*200 +: 200] = dat;
        if (ixi == 7) begin done = 1'b1; m_exp = 0; end
        else m_exp = ixi + 1;
      end else begin
        m_es = 1'b1;
        if (ixi == 0) begin s_cur[199:0] = dat; m_exp = 1; end
        else m_exp = 0;
      end
    end
    for (int m = 0; m < 2; m++) begin
      m_eo[m] = 1'b0;
      if (mcnt[m] > 0 && rdy) begin
        if (mwp[m] == nw[m] - 1) begin
          mq[m][0] = mq[m][1];
          mcnt[m]--;
          mwp[m] = 0;
        end else begin
          mwp[m]++;
        end
      end
      if (done) begin
        if (mcnt[m] < 2) begin
          mq[m][mcnt[m]] = s_cur;
          mcnt[m]++;
        end else begin
          m_eo[m] = 1'b1;
        end
      end
      mec[m] = mec[m] + int'(m_es) + int'(m_eo[m]);
      if (mec[m] > 255) mec[m] = 255;
    end
  endtask

  function automatic logic [63:0] mword(int m);
    logic [1599:0] s;
    s = mq[m][0];
    return s[mwp[m]*64 +: 64];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("v256", {63'd0, v0}, {63'd0, mcnt[0] > 0});
    chk("v512", {63'd0, v1}, {63'd0, mcnt[1] > 0});
    if (mcnt[0] > 0 || was_rst) chk("w256", w0, (mcnt[0] > 0) ? mword(0) : 64'd0);
    if (mcnt[1] > 0 || was_rst) chk("w512", w1, (mcnt[1] > 0) ? mword(1) : 64'd0);
    chk("l256", {63'd0, l0}, {63'd0, mcnt[0] > 0 && mwp[0] == 3});
    chk("l512", {63'd0, l1}, {63'd0, mcnt[1] > 0 && mwp[1] == 7});
    chk("es256", {63'd0, es0}, {63'd0, m_es});
    chk("es512", {63'd0, es1}, {63'd0, m_es});
    chk("eo256", {63'd0, eo0}, {63'd0, m_eo[0]});
    chk("eo512", {63'd0, eo1}, {63'd0, m_eo[1]});
    chk("ec256", {56'd0, ec0}, 64'(mec[0]));
    chk("ec512", {56'd0, ec1}, 64'(mec[1]));
  endtask

  task automatic cyc(input bit p, input int i, input logic [199:0] d, input bit r, input bit rs);
    logic [31:0] iv;
    iv = i;
    push = p; ix = iv[2:0]; dat = d; rdy = r; rst_n = rs;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic frame(input bit r);
    for (int k = 0; k < 8; k++) cyc(1'b1, k, rnd200(), r, 1'b1);
  endtask

  task automatic idle(input int n, input bit r);
    for (int k = 0; k < n; k++) cyc(1'b0, 0, '0, r, 1'b1);
  endtask

  initial begin
    int sq;
    bit p, r;
    s_cur = '0;
    m_exp = 0;
    was_rst = 1'b0;
    m_es = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0; mwp[m] = 0; mec[m] = 0; m_eo[m] = 1'b0;
    end
    push = 1'b0; ix = 3'd0; dat = '0; rdy = 1'b0; rst_n = 1'b0;

    // reset state
    cyc(1'b0, 0, '0, 1'b0, 1'b0);
    cyc(1'b1, 0, rnd200(), 1'b1, 1'b0);
    chk("rst_valid", {63'd0, v0}, 64'd0);
    chk("rst_word", w0, 64'd0);

    // ordered frame, beat0=1, beat1=2
    for (int k = 0; k < 8; k++)
      cyc(1'b1, k, (k == 0) ? 200'h1 : (k == 1) ? 200'h2 : rnd200(), 1'b1, 1'b1);
    chk("ord_valid", {63'd0, v0}, 64'd1);
    chk("ord_w0", w0, 64'h1);
    idle(1, 1'b1);
    chk("ord_w1", w0, 64'h0);
    idle(1, 1'b1);
    chk("ord_w2", w0, 64'h0);
    idle(1, 1'b1);
    chk("ord_w3", w0, 64'h0000_0000_0000_0200);
    chk("ord_last", {63'd0, l0}, 64'd1);
    idle(10, 1'b1);

    // sequence violations
    cyc(1'b0, 0, '0, 1'b1, 1'b0);
    cyc(1'b1, 0, rnd200(), 1'b1, 1'b1);
    cyc(1'b1, 1, rnd200(), 1'b1, 1'b1);
    cyc(1'b1, 3, rnd200(), 1'b1, 1'b1);
    chk("seq_b3", {63'd0, es0}, 64'd1);
    cyc(1'b1, 0, rnd200(), 1'b1, 1'b1);
    cyc(1'b1, 1, rnd200(), 1'b1, 1'b1);
    cyc(1'b1, 0, rnd200(), 1'b1, 1'b1);
    chk("seq_b0", {63'd0, es0}, 64'd1);
    for (int k = 1; k < 8; k++) cyc(1'b1, k, rnd200(), 1'b1, 1'b1);
    idle(12, 1'b1);
    chk("seq_cnt", {56'd0, ec0}, 64'd2);

    // overflow with consumer stalled, then drain
    cyc(1'b0, 0, '0, 1'b0, 1'b0);
    frame(1'b0);
    frame(1'b0);
    frame(1'b0);
    chk("ovf_pulse", {63'd0, eo0}, 64'd1);
    idle(1, 1'b0);
    chk("ovf_cnt", {56'd0, ec0}, 64'd1);
    idle(20, 1'b1);

    // full FIFO: commit coincides with last-word pop
    cyc(1'b0, 0, '0, 1'b0, 1'b0);
    frame(1'b0);
    frame(1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, k, rnd200(), 1'b0, 1'b1);
    for (int k = 4; k < 8; k++) cyc(1'b1, k, rnd200(), 1'b1, 1'b1);
    chk("simul_no_ovf", {63'd0, eo0}, 64'd0);
    idle(30, 1'b1);

    // randomized traffic with random backpressure
    sq = 0;
    for (int n = 0; n < 800; n++) begin
      p = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 1) == 1);
      if (p) begin
        if ($urandom_range(0, 19) == 0) sq = $urandom_range(0, 7);
        cyc(1'b1, sq, rnd200(), r, 1'b1);
        sq = (sq + 1) % 8;
      end else begin
        cyc(1'b0, 0, '0, r, 1'b1);
      end
    end
    idle(40, 1'b1);

    // reset in the middle of buffered data and a partial frame
    frame(1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, k, rnd200(), 1'b0, 1'b1);
    cyc(1'b1, 5, rnd200(), 1'b1, 1'b0);
    chk("mid_rst_valid", {63'd0, v0}, 64'd0);
    chk("mid_rst_cnt", {56'd0, ec0}, 64'd0);
    frame(1'b1);
    idle(12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
